// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done
// handshake; results above the display range saturate to all nines.
module bin_to_bcd_seq #(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  ovf
);

   localparam int SW = 4 * DIGITS;
   localparam int CW = $clog2(BIN_W + 1);

   function automatic logic [31:0] pow10(input int n);
      logic [31:0] p;
      p = 32'd1;
      for (int i = 0; i < n; i++) p = p * 32'd10;
      return p;
   endfunction

   localparam logic [31:0] LIMIT = pow10(DIGITS) - 32'd1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t            state;
   logic [SW-1:0]     scratch;
   logic [SW-1:0]     adj;
   logic [SW-1:0]     nxt_scr;
   logic [BIN_W-1:0]  shreg;
   logic [BIN_W-1:0]  nxt_sh;
   logic [CW-1:0]     cnt;
   logic              sat;
   logic [31:0]       bin_ext;

   assign bin_ext = {{(32-BIN_W){1'b0}}, bin_in};

   // Digits are corrected independently; no carry crosses a digit boundary.
   always_comb begin
      adj = scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (scratch[4*d +: 4] >= 4'd5)
            adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
      {nxt_scr, nxt_sh} = {adj, shreg} << 1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         bcd_out <= '0;
         ovf     <= 1'b0;
         scratch <= '0;
         shreg   <= '0;
         cnt     <= '0;
         sat     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  shreg   <= bin_in;
                  scratch <= '0;
                  cnt     <= CW'(BIN_W);
                  sat     <= bin_ext > LIMIT;
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               scratch <= nxt_scr;
               shreg   <= nxt_sh;
               cnt     <= cnt - 1'b1;
               if (cnt == CW'(1))
                  state <= DONE;
            end
            DONE: begin
               bcd_out <= sat ? {DIGITS{4'h9}} : scratch;
               ovf     <= sat;
               done    <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
